imem_boot_loader: RTL

//  Writer side of the instruction memory: receives a program image as a byte stream

---
 rtl/imem_boot_loader_pkg.sv | 23 ++
 rtl/imem_boot_loader_if.sv | 34 +++
 rtl/imem_boot_loader_byte_packer.sv | 61 ++++++
 rtl/imem_boot_loader.sv | 123 ++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader: the loader state
// encoding and the constants describing the boot frame layout.
// No ports.
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Frame layout: a little-endian 16-bit word count, then 4 bytes per word.
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the byte-stream input from the UART receiver and the instruction
// memory write port.
//   rx_data    [7:0]  received byte
//   rx_valid          rx_data valid
//   rx_ready          loader accepts a byte (taken when rx_valid & rx_ready)
//   imem_we           one-cycle write strobe per assembled word
//   imem_addr  [W-1]  word-aligned byte address
//   imem_wdata [W-1]  assembled instruction word
// master: the loader side; slave: the UART / memory side.
// -----------------------------------------------------------------------------
interface imem_boot_loader_if #(
  parameter int WIDTH = 32
);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             imem_we;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Collects bytes into little-endian 32-bit words (first byte -> [7:0]).
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clear         restart at byte 0 of a new word
//   i_valid         a byte is accepted this cycle
//   i_byte  [7:0]   the accepted byte
//   o_word  [31:0]  last completed word, held until the next one completes
//   o_idx   [1:0]   index of the next byte within the word
//   o_last          the byte accepted this cycle completes a word
//   o_word_ready    one-cycle pulse, the cycle after a word completes
// -----------------------------------------------------------------------------
module byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx,
  output logic        o_last,
  output logic        o_word_ready
);

  logic [1:0]  r_idx;
  logic [23:0] r_partial;
  logic [31:0] r_word;
  logic        r_ready;

  assign o_last       = i_valid && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word       = r_word;
  assign o_idx        = r_idx;
  assign o_word_ready = r_ready;

  // The completed word is formed directly from the top byte and the three
  // buffered ones, so the word register only changes on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_partial <= '0;
      r_word    <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_ready <= o_last;
      if (i_clear) begin
        r_idx <= '0;
      end else if (i_valid) begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_partial[7:0]   <= i_byte;
          2'd1:    r_partial[15:8]  <= i_byte;
          2'd2:    r_partial[23:16] <= i_byte;
          default: r_word           <= {i_byte, r_partial};
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Receives a program image as a byte stream and writes it word by word into
// the instruction memory. The core is held in reset until a complete image
// with a matching XOR checksum has been loaded.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        one-cycle pulse: begin a load (only from IDLE/DONE/ERROR)
//   bus            rx byte stream in, instruction-memory write port out
//   o_cpu_hold     1 = keep the core in reset (low only in DONE)
//   o_load_done    image loaded and checksum good
//   o_load_error   bad checksum or image larger than MEM_DEPTH words
// -----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               MEM_DEPTH = 256,
  parameter logic [WIDTH-1:0] ADDR_BASE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  imem_boot_loader_if.master  bus,
  output logic                o_cpu_hold,
  output logic                o_load_done,
  output logic                o_load_error
);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_len;
  logic [15:0]      r_wcnt;
  logic [7:0]       r_csum;
  logic [WIDTH-1:0] r_addr;

  logic        w_accept;
  logic        w_restart;
  logic        w_data_accept;
  logic        w_last;
  logic        w_final_word;
  logic        w_word_ready;
  logic [1:0]  w_idx;
  logic [31:0] w_word;
  logic [15:0] w_len_full;

  assign bus.rx_ready  = (r_state inside {LEN_LO, LEN_HI, DATA, CHECK});
  assign w_accept      = bus.rx_valid && bus.rx_ready;
  assign w_restart     = i_start && (r_state inside {IDLE, DONE, ERROR});
  assign w_data_accept = w_accept && (r_state == DATA);
  assign w_len_full    = {bus.rx_data, r_len[7:0]};
  // DATA is only entered with r_len >= 1, so r_len - 1 never wraps there.
  assign w_final_word  = w_last && (r_wcnt == r_len - 16'd1);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_restart),
    .i_valid      (w_data_accept),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_idx        (w_idx),
    .o_last       (w_last),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Header decode happens on the LEN_HI byte itself, so an empty image goes
  // straight to the checksum and an oversize one is rejected immediately.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (i_start) w_next = LEN_LO;
      LEN_LO:            if (w_accept) w_next = LEN_HI;
      LEN_HI: begin
        if (w_accept) begin
          if (w_len_full == 16'd0)                           w_next = CHECK;
          else if ({16'd0, w_len_full} > 32'(MEM_DEPTH))     w_next = ERROR;
          else                                               w_next = DATA;
        end
      end
      DATA:              if (w_final_word) w_next = CHECK;
      CHECK:             if (w_accept) w_next = (bus.rx_data == r_csum) ? DONE : ERROR;
      default:           w_next = IDLE;
    endcase
  end

  // Length capture, running checksum, word counter and write address. The
  // address is latched together with the completed word so both appear on
  // the write port in the strobe cycle and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_wcnt <= '0;
      r_csum <= '0;
      r_addr <= ADDR_BASE;
    end else if (w_restart) begin
      r_len  <= '0;
      r_wcnt <= '0;
      r_csum <= '0;
    end else begin
      if (w_accept && (r_state == LEN_LO)) r_len[7:0]  <= bus.rx_data;
      if (w_accept && (r_state == LEN_HI)) r_len[15:8] <= bus.rx_data;
      if (w_data_accept)                   r_csum      <= r_csum ^ bus.rx_data;
      if (w_last) begin
        r_wcnt <= r_wcnt + 16'd1;
        r_addr <= ADDR_BASE + WIDTH'({r_wcnt, 2'b00});
      end
    end
  end

  assign bus.imem_we    = w_word_ready;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = WIDTH'(w_word);

  assign o_cpu_hold   = (r_state != DONE);
  assign o_load_done  = (r_state == DONE);
  assign o_load_error = (r_state == ERROR);

endmodule
